// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
package alu_seq_pkg;

    localparam int unsigned OPND_W = 2;
    localparam int unsigned Y_W    = 4;
    localparam int unsigned ERR_W  = 4;

    localparam logic [OPND_W-1:0] OP_ADD = 2'b00;
    localparam logic [OPND_W-1:0] OP_SUB = 2'b01;
    localparam logic [OPND_W-1:0] OP_MUL = 2'b10;
    localparam logic [OPND_W-1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef struct packed {
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        logic [OPND_W-1:0] op;
    } alu_req_t;

    function automatic logic is_div_zero(input logic [OPND_W-1:0] op, input logic [OPND_W-1:0] b);
        return (op == OP_DIV) && (b == '0);
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Request FIFO with first-word fall-through head; DEPTH must be a power of two.
module alu_req_fifo
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  logic     pop,
    input  alu_req_t din,
    output logic     full,
    output logic     empty,
    output alu_req_t dout
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    alu_req_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues queued 2-bit ALU requests one at a time and returns captured results
// over a valid/ready handshake, counting divide-by-zero issues.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_a,
    input  logic [1:0]        in_b,
    input  logic [1:0]        in_op,
    output logic [1:0]        alu_a,
    output logic [1:0]        alu_b,
    output logic [1:0]        alu_ctrl,
    output logic [ADDR_W-1:0] alu_addr,
    output logic              alu_we,
    input  logic [3:0]        alu_y,
    input  logic              alu_c,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [3:0]        res_y,
    output logic              res_c,
    output logic [ADDR_W-1:0] res_addr,
    output logic              busy,
    output logic [3:0]        err_count
);

    state_e            state;
    alu_req_t          req_in;
    alu_req_t          head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] addr_cnt;

    assign req_in   = '{a: in_a, b: in_b, op: in_op};
    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;
    // Head leaves the FIFO when the FSM starts an issue from IDLE or straight out of RESP.
    assign pop      = !empty && ((state == IDLE) || ((state == RESP) && res_ready));
    assign alu_addr = addr_cnt;
    assign busy     = !empty || (state != IDLE);

    alu_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (req_in),
        .full  (full),
        .empty (empty),
        .dout  (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_ctrl  <= '0;
            alu_we    <= 1'b0;
            addr_cnt  <= '0;
            res_valid <= 1'b0;
            res_y     <= '0;
            res_c     <= 1'b0;
            res_addr  <= '0;
            err_count <= '0;
        end else begin
            alu_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        alu_a    <= head.a;
                        alu_b    <= head.b;
                        alu_ctrl <= head.op;
                        alu_we   <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    res_y     <= alu_y;
                    res_c     <= alu_c;
                    res_addr  <= addr_cnt;
                    res_valid <= 1'b1;
                    addr_cnt  <= addr_cnt + ADDR_W'(1);
                    if (is_div_zero(alu_ctrl, alu_b) && (err_count != 4'hF)) begin
                        err_count <= err_count + 4'(1);
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (pop) begin
                            alu_a    <= head.a;
                            alu_b    <= head.b;
                            alu_ctrl <= head.op;
                            alu_we   <= 1'b1;
                            state    <= ISSUE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU stand-in.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    localparam int unsigned ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        in_a = '0;
    logic [1:0]        in_b = '0;
    logic [1:0]        in_op = '0;
    logic [1:0]        alu_a, alu_b, alu_ctrl;
    logic [ADDR_W-1:0] alu_addr;
    logic              alu_we;
    logic [3:0]        alu_y;
    logic              alu_c;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic [3:0]        res_y;
    logic              res_c;
    logic [ADDR_W-1:0] res_addr;
    logic              busy;
    logic [3:0]        err_count;

    always #5 clk = ~clk;

    alu_op_sequencer #(.DEPTH(4), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_addr(alu_addr), .alu_we(alu_we),
        .alu_y(alu_y), .alu_c(alu_c),
        .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y), .res_c(res_c), .res_addr(res_addr),
        .busy(busy), .err_count(err_count)
    );

    // Arithmetic meaning of each op: {flag, 4-bit result}
    function automatic logic [4:0] alu_ref(input logic [1:0] a, input logic [1:0] b, input logic [1:0] op);
        case (op)
            2'b00:   return {1'b0, 4'(4'(a) + 4'(b))};
            2'b01:   return {(a < b), 4'(4'(a) - 4'(b))};
            2'b10:   return {1'b0, 4'(4'(a) * 4'(b))};
            default: return (b == 2'd0) ? 5'b1_0000 : {1'b0, 4'(a / b)};
        endcase
    endfunction

    logic [4:0] alu_out;
    assign alu_out = alu_ref(alu_a, alu_b, alu_ctrl);
    assign alu_y   = alu_out[3:0];
    assign alu_c   = alu_out[4];

    typedef struct {
        logic [1:0] a, b, op;
        logic [3:0] y;
        logic       c;
        logic [1:0] addr;
        logic [3:0] err;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         addr_m = 0;
    int         err_m = 0;
    logic       tput_on = 1'b0;
    int         tput_n = 0;
    int         last_hs = 0;
    logic       rnd_done = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Expected outcome is queued at acceptance; monitor retires it in order.
    task automatic push(input logic [1:0] a, input logic [1:0] b, input logic [1:0] op);
        exp_t       e;
        logic [4:0] r;
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (in_ready) break;
            if (t >= 300) begin
                fail_now("push_timeout");
                in_valid = 1'b0;
                return;
            end
        end
        r = alu_ref(a, b, op);
        if (op == OP_DIV && b == 2'd0 && err_m < 15) err_m++;
        e = '{a: a, b: b, op: op, y: r[3:0], c: r[4], addr: 2'(addr_m), err: 4'(err_m)};
        addr_m = (addr_m + 1) % 4;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int t = 0; t < budget; t++) begin
            if (sb.size() == 0) break;
            @(posedge clk); #1;
        end
        if (sb.size() != 0) fail_now("drain_timeout");
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: issue checks, result retirement, hold stability, throughput.
    logic       prev_we = 1'b0;
    logic       hold_v = 1'b0;
    logic [3:0] hold_y;
    logic       hold_c;
    logic [1:0] hold_a;
    exp_t       got;

    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (alu_we) begin
                chk("we_consecutive", 32'(prev_we), 32'd0);
                if (sb.size() == 0) begin
                    fail_now("issue_without_request");
                end else begin
                    chk("issue_a", 32'(alu_a), 32'(sb[0].a));
                    chk("issue_b", 32'(alu_b), 32'(sb[0].b));
                    chk("issue_ctrl", 32'(alu_ctrl), 32'(sb[0].op));
                    chk("issue_addr", 32'(alu_addr), 32'(sb[0].addr));
                end
            end
            if (res_valid && hold_v) begin
                chk("hold_y", 32'(res_y), 32'(hold_y));
                chk("hold_c", 32'(res_c), 32'(hold_c));
                chk("hold_addr", 32'(res_addr), 32'(hold_a));
            end
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    fail_now("result_without_request");
                end else begin
                    got = sb.pop_front();
                    chk("res_y", 32'(res_y), 32'(got.y));
                    chk("res_c", 32'(res_c), 32'(got.c));
                    chk("res_addr", 32'(res_addr), 32'(got.addr));
                    chk("err_count", 32'(err_count), 32'(got.err));
                end
                if (tput_on) begin
                    if (tput_n > 0) chk("tput_gap", 32'(cyc - last_hs), 32'd2);
                    last_hs = cyc;
                    tput_n++;
                end
                hold_v = 1'b0;
            end else if (res_valid) begin
                hold_v = 1'b1;
                hold_y = res_y;
                hold_c = res_c;
                hold_a = res_addr;
            end else begin
                hold_v = 1'b0;
            end
        end
        prev_we = alu_we;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_alu_we", 32'(alu_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        chk("rst_addr", 32'(alu_addr), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Add 2+1 with latency probe
        push(2'd2, 2'd1, OP_ADD);
        @(negedge clk);
        chk("lat_idle_we", 32'(alu_we), 32'd0);
        @(negedge clk);
        chk("lat_issue_we", 32'(alu_we), 32'd1);
        chk("lat_issue_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        chk("lat_resp_valid", 32'(res_valid), 32'd1);
        chk("lat_resp_we", 32'(alu_we), 32'd0);
        @(posedge clk); #1;
        drain(50);

        // Sub then mul
        push(2'd1, 2'd2, OP_SUB);
        push(2'd2, 2'd2, OP_MUL);
        drain(50);

        // Divide by zero and saturation
        push(2'd2, 2'd0, OP_DIV);
        drain(50);
        chk("err_one", 32'(err_count), 32'd1);
        for (int i = 0; i < 16; i++) push(2'd2, 2'd0, OP_DIV);
        drain(200);
        chk("err_sat", 32'(err_count), 32'd15);

        // Back-to-back adds, address wrap, throughput
        tput_on = 1'b1; tput_n = 0;
        for (int i = 0; i < 5; i++) push(2'(i), 2'd1, OP_ADD);
        drain(100);
        tput_on = 1'b0;
        chk("tput_count", 32'(tput_n), 32'd5);

        // Backpressure fills the FIFO
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(2'(i), 2'(3 - i), OP_SUB);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_res_valid", 32'(res_valid), 32'd1);
        @(posedge clk); #1;
        res_ready = 1'b1;
        push(2'd3, 2'd3, OP_MUL);
        drain(100);

        // Reset during ISSUE with two queued
        res_ready = 1'b0;
        push(2'd1, 2'd1, OP_ADD);
        for (int i = 0; i < 3; i++) push(2'd3, 2'(i), OP_DIV);
        res_ready = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (alu_we) break;
            if (t >= 50) begin
                fail_now("rst_wait_issue");
                break;
            end
        end
        #1 rst = 1'b1;
        @(posedge clk); #1;
        sb.delete();
        addr_m = 0;
        err_m  = 0;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_we", 32'(alu_we), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_err", 32'(err_count), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        push(2'd3, 2'd2, OP_ADD);
        drain(50);

        // Randomized traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 120; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    push(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    res_ready = ($urandom_range(0, 3) != 0);
                end
                res_ready = 1'b1;
            end
        join
        drain(1000);
        @(negedge clk);
        chk("end_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
